// File: rtl/sys_irq_ctrl_pkg.sv
// sys_irq_ctrl shared definitions: register map and field widths
// for the interrupt aggregator sitting behind sys_timer.
package sys_irq_ctrl_pkg;

    localparam logic [2:0] ADDR_RAW      = 3'd0;
    localparam logic [2:0] ADDR_PENDING  = 3'd1;
    localparam logic [2:0] ADDR_ENABLE   = 3'd2;
    localparam logic [2:0] ADDR_EDGE_SEL = 3'd3;
    localparam logic [2:0] ADDR_ACTIVE   = 3'd4;
    localparam logic [2:0] ADDR_FORCE    = 3'd5;
    localparam logic [2:0] ADDR_OVERRUN  = 3'd6;

    localparam int ACTIVE_VALID_BIT = 15;
    localparam int ID_W             = 4;
    localparam int MAX_SRC          = 15;

endpackage

// File: rtl/sys_irq_prio_enc.sv
// Lowest-index-first priority encoder over the enabled pending
// sources; purely combinational.
module sys_irq_prio_enc
    import sys_irq_ctrl_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]    req,
    output logic            valid,
    output logic [ID_W-1:0] id
);

    always_comb begin
        id = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) id = ID_W'(i);
        end
    end

    assign valid = |req;

endmodule

// File: rtl/sys_irq_ctrl.sv
// Avalon-MM interrupt aggregator: per-source edge/level capture,
// sticky pending, enable mask, overrun flags and a registered irq.
module sys_irq_ctrl
    import sys_irq_ctrl_pkg::*;
#(
    parameter int                  NUM_SRC      = 8,
    parameter logic [NUM_SRC-1:0]  EDGE_DEFAULT = 'h01,
    parameter bit                  SYNC_EN      = 1'b0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_SRC-1:0] irq_in,
    output logic               irq
);

    logic [NUM_SRC-1:0] s;
    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] ovr_q, ovr_d;
    logic [NUM_SRC-1:0] en_q, en_d;
    logic [NUM_SRC-1:0] esel_q, esel_d;
    logic [15:0]        readdata_q, readdata_d;
    logic               irq_q, irq_d;

    logic [NUM_SRC-1:0] wdata;
    logic [NUM_SRC-1:0] w1c_pend, w1c_ovr, force_set;
    logic [NUM_SRC-1:0] rise, set_pend;
    logic               wr;
    logic               act_valid;
    logic [ID_W-1:0]    act_id;
    logic               unused_wdata;

    if (SYNC_EN) begin : g_sync
        logic [NUM_SRC-1:0] sync1_q, sync2_q;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync1_q <= '0;
                sync2_q <= '0;
            end else begin
                sync1_q <= irq_in;
                sync2_q <= sync1_q;
            end
        end
        assign s = sync2_q;
    end else begin : g_nosync
        assign s = irq_in;
    end

    assign wr           = chipselect && !write_n;
    assign wdata        = writedata[NUM_SRC-1:0];
    assign unused_wdata = ^writedata[15:NUM_SRC];

    assign w1c_pend  = (wr && address == ADDR_PENDING)  ? wdata : '0;
    assign w1c_ovr   = (wr && address == ADDR_OVERRUN)  ? wdata : '0;
    assign force_set = (wr && address == ADDR_FORCE)    ? wdata : '0;

    assign rise = s & ~prev_q;

    sys_irq_prio_enc #(
        .N (NUM_SRC)
    ) u_prio (
        .req   (pend_q & en_q),
        .valid (act_valid),
        .id    (act_id)
    );

    always_comb begin
        // set always beats a same-cycle clear
        set_pend = force_set | (esel_q & rise) | (~esel_q & s);
        pend_d   = set_pend | (pend_q & ~w1c_pend);
        ovr_d    = (esel_q & rise & pend_q & ~w1c_pend)
                 | (ovr_q & ~w1c_ovr);
        en_d     = (wr && address == ADDR_ENABLE)   ? wdata : en_q;
        esel_d   = (wr && address == ADDR_EDGE_SEL) ? wdata : esel_q;
        irq_d    = |(pend_q & en_q);
    end

    always_comb begin
        readdata_d = '0;
        unique case (address)
            ADDR_RAW:      readdata_d = 16'(s);
            ADDR_PENDING:  readdata_d = 16'(pend_q);
            ADDR_ENABLE:   readdata_d = 16'(en_q);
            ADDR_EDGE_SEL: readdata_d = 16'(esel_q);
            ADDR_ACTIVE: begin
                if (act_valid) begin
                    readdata_d[ACTIVE_VALID_BIT] = 1'b1;
                    readdata_d[ID_W-1:0]         = act_id;
                end
            end
            ADDR_OVERRUN:  readdata_d = 16'(ovr_q);
            default:       readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            pend_q     <= '0;
            ovr_q      <= '0;
            en_q       <= '0;
            esel_q     <= EDGE_DEFAULT;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            prev_q     <= s;
            pend_q     <= pend_d;
            ovr_q      <= ovr_d;
            en_q       <= en_d;
            esel_q     <= esel_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_sys_irq_ctrl.sv
// Directed self-checking bench for sys_irq_ctrl (NUM_SRC=8,
// SYNC_EN=0); expected values are hand-computed per step.
module tb_sys_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic [7:0]  irq_in;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [15:0] rv;

    sys_irq_ctrl #(
        .NUM_SRC      (8),
        .EDGE_DEFAULT (8'h01),
        .SYNC_EN      (1'b0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_in     (irq_in),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [15:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        tick();
        d          = readdata;
        chipselect = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        irq_in     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_irq", 16'(irq), 16'h0);
        chk("rst_rdata", readdata, 16'h0);
        #3 reset_n = 1'b1;
        tick();

        rd(3'd3, rv); chk("rst_edge_sel", rv, 16'h0001);
        rd(3'd2, rv); chk("rst_enable", rv, 16'h0000);

        // edge capture and clear
        wr(3'd2, 16'h0001);
        irq_in[0] = 1'b1;
        tick();
        irq_in[0] = 1'b0;
        chk("edge_irq_1cyc", 16'(irq), 16'h0);
        tick();
        chk("edge_irq_2cyc", 16'(irq), 16'h1);
        rd(3'd1, rv); chk("edge_pending", rv, 16'h0001);
        rd(3'd4, rv); chk("edge_active", rv, 16'h8000);
        wr(3'd1, 16'h0001);
        tick();
        chk("edge_w1c_irq", 16'(irq), 16'h0);
        rd(3'd1, rv); chk("edge_w1c_pend", rv, 16'h0000);

        // level mode
        wr(3'd3, 16'h0000);
        wr(3'd2, 16'h0004);
        irq_in[2] = 1'b1;
        tick();
        tick();
        wr(3'd1, 16'h0004);
        rd(3'd1, rv); chk("lvl_pend_held", rv, 16'h0004);
        chk("lvl_irq_held", 16'(irq), 16'h1);
        irq_in[2] = 1'b0;
        tick();
        wr(3'd1, 16'h0004);
        tick();
        rd(3'd1, rv); chk("lvl_pend_clr", rv, 16'h0000);
        chk("lvl_irq_clr", 16'(irq), 16'h0);

        // priority
        wr(3'd3, 16'h00FF);
        wr(3'd2, 16'h00FF);
        wr(3'd5, 16'h0048);
        rd(3'd4, rv); chk("prio_3", rv, 16'h8003);
        rd(3'd5, rv); chk("force_reads0", rv, 16'h0000);
        wr(3'd1, 16'h0008);
        rd(3'd4, rv); chk("prio_6", rv, 16'h8006);
        wr(3'd2, 16'h0000);
        tick();
        rd(3'd4, rv); chk("prio_none", rv, 16'h0000);
        chk("prio_irq_off", 16'(irq), 16'h0);
        rd(3'd1, rv); chk("prio_pend_kept", rv, 16'h0040);
        wr(3'd1, 16'h00FF);

        // overrun and simultaneity
        irq_in[0] = 1'b1; tick();
        irq_in[0] = 1'b0; tick();
        irq_in[0] = 1'b1; tick();
        irq_in[0] = 1'b0; tick();
        rd(3'd6, rv); chk("ovr_set", rv, 16'h0001);
        wr(3'd6, 16'h0001);
        rd(3'd6, rv); chk("ovr_w1c", rv, 16'h0000);
        rd(3'd1, rv); chk("ovr_pend", rv, 16'h0001);
        irq_in[0]  = 1'b1;
        address    = 3'd1;
        writedata  = 16'h0001;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        irq_in[0]  = 1'b0;
        rd(3'd1, rv); chk("simul_pend", rv, 16'h0001);
        rd(3'd6, rv); chk("simul_ovr", rv, 16'h0000);

        // reset mid-operation
        wr(3'd2, 16'h00FF);
        wr(3'd5, 16'h00FF);
        tick();
        chk("pre_rst_irq", 16'(irq), 16'h1);
        rd(3'd1, rv); chk("pre_rst_pend", rv, 16'h00FF);
        irq_in[0] = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("async_irq", 16'(irq), 16'h0);
        chk("async_rdata", readdata, 16'h0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        tick();
        rd(3'd1, rv); chk("post_pend", rv, 16'h0001);
        rd(3'd2, rv); chk("post_enable", rv, 16'h0000);
        rd(3'd3, rv); chk("post_esel", rv, 16'h0001);
        rd(3'd6, rv); chk("post_ovr", rv, 16'h0000);
        rd(3'd4, rv); chk("post_active", rv, 16'h0000);

        // read-path corners
        rd(3'd7, rv); chk("addr7", rv, 16'h0000);
        wr(3'd2, 16'hFFFF);
        rd(3'd2, rv); chk("enable_mask", rv, 16'h00FF);
        irq_in = 8'hA5;
        tick();
        rd(3'd0, rv); chk("raw", rv, 16'h00A5);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
